// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with frame-synchronised loads,
// leading-zero suppression, per-digit DP/blanking and PWM brightness.
module seg7_scan_driver #(
    parameter int N_DIGITS    = 4,
    parameter int DIV         = 50000,
    parameter int GUARD       = 2,
    parameter int PWM_BITS    = 4,
    parameter int SEG_ACT_LOW = 1,
    parameter int DIG_ACT_LOW = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4*N_DIGITS-1:0] data_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    input  logic [N_DIGITS-1:0]   blank_i,
    input  logic                  lzs_i,
    input  logic                  load_i,
    output logic                  load_ack_o,
    input  logic [PWM_BITS-1:0]   bright_i,
    output logic [7:0]            seg_o,
    output logic [N_DIGITS-1:0]   dig_o,
    output logic                  frame_o
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0]       CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0]       CNT_GUARD = CW'(GUARD);
    localparam logic [IW-1:0]       IDX_LAST  = IW'(N_DIGITS - 1);
    localparam logic [7:0]          SEG_OFF   = {8{(SEG_ACT_LOW != 0)}};
    localparam logic [N_DIGITS-1:0] DIG_OFF   = {N_DIGITS{(DIG_ACT_LOW != 0)}};

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic                  tick;
    logic                  fb;

    logic [4*N_DIGITS-1:0] pend_data;
    logic [N_DIGITS-1:0]   pend_dp;
    logic [N_DIGITS-1:0]   pend_blank;
    logic                  pend_lzs;
    logic                  pend_flag;

    logic [4*N_DIGITS-1:0] disp_data;
    logic [N_DIGITS-1:0]   disp_dp;
    logic [N_DIGITS-1:0]   disp_blank;
    logic                  disp_lzs;

    logic [N_DIGITS-1:0]   supp;
    logic                  zero_run;
    logic [3:0]            nib;
    logic [6:0]            glyph;
    logic [7:0]            seg_pat;
    logic [N_DIGITS-1:0]   dig_pat;

    assign tick = (cnt == CNT_LAST);
    assign fb   = tick && (idx == IDX_LAST);

    // A digit is suppressed when it and every digit above it hold zero.
    always_comb begin
        supp     = '0;
        zero_run = 1'b1;
        for (int unsigned j = 1; j < N_DIGITS; j++) begin
            zero_run              = zero_run && (disp_data[4*(N_DIGITS-j) +: 4] == 4'h0);
            supp[N_DIGITS-j]      = disp_lzs && zero_run;
        end
    end

    always_comb begin
        nib   = disp_data[4*idx +: 4];
        glyph = 7'h00;
        case (nib)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            4'hF: glyph = 7'h71;
            default: glyph = 7'h00;
        endcase

        seg_pat = 8'h00;
        if (!disp_blank[idx]) begin
            seg_pat[7]   = disp_dp[idx];
            seg_pat[6:0] = supp[idx] ? 7'h00 : glyph;
        end

        dig_pat = '0;
        if ((cnt >= CNT_GUARD) && (pwm_cnt <= bright_i)) begin
            dig_pat[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt        <= '0;
            idx        <= '0;
            pwm_cnt    <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_lzs   <= 1'b0;
            pend_flag  <= 1'b0;
            disp_data  <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
            disp_lzs   <= 1'b0;
            seg_o      <= SEG_OFF;
            dig_o      <= DIG_OFF;
            frame_o    <= 1'b0;
            load_ack_o <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (tick) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (load_i) begin
                pend_data  <= data_i;
                pend_dp    <= dp_i;
                pend_blank <= blank_i;
                pend_lzs   <= lzs_i;
            end

            // A load landing on the commit cycle re-arms the flag for the next frame.
            if (fb && pend_flag) begin
                disp_data  <= pend_data;
                disp_dp    <= pend_dp;
                disp_blank <= pend_blank;
                disp_lzs   <= pend_lzs;
                pend_flag  <= load_i;
            end else if (load_i) begin
                pend_flag <= 1'b1;
            end

            load_ack_o <= fb && pend_flag;
            frame_o    <= fb;
            seg_o      <= seg_pat ^ SEG_OFF;
            dig_o      <= dig_pat ^ DIG_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: timing model of the scan plus a
// commit scoreboard, table-driven display vectors and multi-cycle corner cases.
module tb_seg7_scan_driver;
    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int FRAME = N * DIV;
    localparam int DIV2  = 64;

    logic        clk;
    logic        rst_i;
    logic [15:0] data_i;
    logic [3:0]  dp_i;
    logic [3:0]  blank_i;
    logic        lzs_i;
    logic        load_i;
    logic [3:0]  bright_i;
    logic        load_ack_o;
    logic [7:0]  seg_o;
    logic [3:0]  dig_o;
    logic        frame_o;
    logic        ack2;
    logic [7:0]  seg2;
    logic [3:0]  dig2;
    logic        frame2;

    seg7_scan_driver #(
        .N_DIGITS(N), .DIV(DIV), .GUARD(2), .PWM_BITS(4), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .dp_i(dp_i), .blank_i(blank_i),
        .lzs_i(lzs_i), .load_i(load_i), .load_ack_o(load_ack_o), .bright_i(bright_i),
        .seg_o(seg_o), .dig_o(dig_o), .frame_o(frame_o)
    );

    seg7_scan_driver #(
        .N_DIGITS(N), .DIV(DIV2), .GUARD(2), .PWM_BITS(4), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
    ) dut_pwm (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .dp_i(dp_i), .blank_i(blank_i),
        .lzs_i(lzs_i), .load_i(load_i), .load_ack_o(ack2), .bright_i(bright_i),
        .seg_o(seg2), .dig_o(dig2), .frame_o(frame2)
    );

    typedef struct {
        int              due;
        logic [3:0][7:0] segs;
    } sb_t;

    typedef struct {
        logic [15:0]     data;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic            lzs;
        logic [3:0][7:0] segs;
    } vec_t;

    sb_t             sb[$];
    vec_t            vecs[8];
    logic [3:0][7:0] exp_disp;
    int              st;
    int              n_checks;
    int              n_errors;
    logic            mon_en;
    logic [3:0]      bright_prev;

    int              mj;
    int              mslot;
    logic [3:0]      med;
    logic            mack;
    sb_t             mpop;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // st = index of the scan state currently held (0 = state right after reset)
    always @(posedge clk) begin
        if (!rst_i) st <= 0;
        else        st <= st + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < FRAME && (st % FRAME) != ph; i++) step(1);
    endtask

    task automatic expect_commit(input logic [3:0][7:0] segs);
        sb_t e;
        int  due;
        due = ((st % FRAME) == FRAME - 1) ? st + FRAME : st - (st % FRAME) + FRAME - 1;
        if (sb.size() > 0 && sb[sb.size()-1].due == due) e = sb.pop_back();
        e.due  = due;
        e.segs = segs;
        sb.push_back(e);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                           input logic lz, input logic [3:0][7:0] segs);
        data_i  = d;
        dp_i    = dp;
        blank_i = bl;
        lzs_i   = lz;
        load_i  = 1'b1;
        expect_commit(segs);
        step(1);
        load_i  = 1'b0;
        data_i  = 16'($urandom);
        dp_i    = 4'($urandom);
        blank_i = 4'($urandom);
        lzs_i   = 1'($urandom);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3 * FRAME && sb.size() > 0; i++) step(1);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic pwm_count(input string name, input int exp_n);
        int         n;
        logic [3:0] ed;
        n = 0;
        step(1);
        for (int i = 0; i < 2 * DIV2 && ((st - 1) % DIV2) != 16; i++) step(1);
        for (int i = 0; i < 48; i++) begin
            if (dig2 != 4'hF) begin
                n++;
                ed = 4'hF;
                ed[((st - 1) / DIV2) % N] = 1'b0;
                chk("pwm_onehot", dig2, ed);
            end
            step(1);
        end
        chk(name, n, exp_n);
    endtask

    // Cycle monitor: compares every output against the timing model and scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (st == 0) begin
                chk("reset_seg", seg_o, 8'hFF);
                chk("reset_dig", dig_o, 4'hF);
                chk("reset_frame", frame_o, 1'b0);
                chk("reset_ack", load_ack_o, 1'b0);
            end else begin
                mj    = st - 1;
                mslot = (mj / DIV) % N;
                med   = 4'hF;
                if ((mj % DIV) >= 2 && (mj % 16) <= int'(bright_prev)) med[mslot] = 1'b0;
                mack  = (sb.size() > 0) && (sb[0].due == mj);
                chk("seg", seg_o, exp_disp[mslot]);
                chk("dig", dig_o, med);
                chk("frame", frame_o, (mj % FRAME) == FRAME - 1);
                chk("ack", load_ack_o, mack);
                if (mack) begin
                    mpop     = sb.pop_front();
                    exp_disp = mpop.segs;
                end
            end
            bright_prev = bright_i;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        n_checks    = 0;
        n_errors    = 0;
        mon_en      = 1'b0;
        rst_i       = 1'b0;
        load_i      = 1'b0;
        data_i      = '0;
        dp_i        = '0;
        blank_i     = '0;
        lzs_i       = 1'b0;
        bright_i    = 4'hF;
        bright_prev = 4'hF;
        exp_disp    = {4{8'hC0}};

        vecs[0] = '{16'h1234, 4'b0001, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h19}};
        vecs[1] = '{16'h0050, 4'b0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'h92, 8'hC0}};
        vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vecs[3] = '{16'h89AB, 4'b1010, 4'b0100, 1'b0, {8'h00, 8'hFF, 8'h08, 8'h83}};
        vecs[4] = '{16'hCDEF, 4'b0000, 4'b0000, 1'b1, {8'hC6, 8'hA1, 8'h86, 8'h8E}};
        vecs[5] = '{16'h0567, 4'b1000, 4'b0000, 1'b1, {8'h7F, 8'h92, 8'h82, 8'hF8}};
        vecs[6] = '{16'h0900, 4'b0000, 4'b0000, 1'b1, {8'hFF, 8'h90, 8'hC0, 8'hC0}};
        vecs[7] = '{16'h1000, 4'b0000, 4'b0001, 1'b0, {8'hF9, 8'hC0, 8'hC0, 8'hFF}};

        // Reset with a load strobe held high: the load must be discarded.
        @(posedge clk);
        #1;
        mon_en  = 1'b1;
        load_i  = 1'b1;
        data_i  = 16'hFFFF;
        dp_i    = 4'hF;
        step(3);
        load_i  = 1'b0;
        rst_i   = 1'b1;
        step(2 * FRAME + 6);

        // Table-driven display vectors, each loaded at an arbitrary cycle.
        for (int v = 0; v < 8; v++) begin
            step($urandom_range(0, 40));
            do_load(vecs[v].data, vecs[v].dp, vecs[v].blank, vecs[v].lzs, vecs[v].segs);
            wait_drain();
            step(FRAME + 2);
        end

        // Two loads in one frame: last wins, single ack.
        wait_phase(5);
        do_load(16'hAAAA, 4'h0, 4'h0, 1'b0, {4{8'h88}});
        wait_phase(10);
        do_load(16'hBBBB, 4'h0, 4'h0, 1'b0, {4{8'h83}});
        wait_drain();
        step(FRAME + 2);

        // Minimum load-to-ack latency: load one cycle before the frame boundary.
        wait_phase(FRAME - 2);
        s = st;
        do_load(16'h7777, 4'h0, 4'h0, 1'b0, {4{8'hF8}});
        for (int i = 0; i < 2 * FRAME && !load_ack_o; i++) step(1);
        chk("latency_min", st - s, 2);
        step(FRAME + 2);

        // Load on the boundary cycle: older pending data commits now, new data a frame later.
        wait_phase(20);
        do_load(16'h3333, 4'h0, 4'h0, 1'b0, {4{8'hB0}});
        wait_phase(FRAME - 1);
        s = st;
        do_load(16'h6666, 4'h0, 4'h0, 1'b0, {4{8'h82}});
        chk("ack_old_on_fb", load_ack_o, 1'b1);
        step(1);
        for (int i = 0; i < 2 * FRAME && !load_ack_o; i++) step(1);
        chk("latency_fb", st - s, FRAME + 1);
        step(FRAME + 2);

        // PWM duty over the 48 post-guard cycles 16..63 of a 64-cycle slot.
        bright_i = 4'h0;
        pwm_count("pwm_bright0", 3);
        bright_i = 4'h7;
        pwm_count("pwm_bright7", 24);
        bright_i = 4'hF;
        pwm_count("pwm_bright15", 48);
        step(2);

        // Mid-slot reset with a pending load: no ack, display returns to zeros.
        wait_phase(3);
        do_load(16'h9999, 4'h0, 4'h0, 1'b0, {4{8'h90}});
        wait_phase(12);
        rst_i = 1'b0;
        step(1);
        sb.delete();
        exp_disp = {4{8'hC0}};
        chk("midreset_seg", seg_o, 8'hFF);
        chk("midreset_dig", dig_o, 4'hF);
        chk("midreset_ack", load_ack_o, 1'b0);
        load_i = 1'b1;
        data_i = 16'h5555;
        step(2);
        load_i = 1'b0;
        rst_i  = 1'b1;
        step(3 * FRAME);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multiplexed 7-segment display driver for N common-anode/cathode digits, running directly from the system clock. An internal prescaler sets the scan rate. The block adds features for front-panel and debug displays:

- tear-free, frame-synchronised data load with acknowledge
- per-digit decimal point and blanking
- leading-zero suppression
- PWM brightness control
- inter-digit ghosting guard

## Interface

Parameters:
- N_DIGITS, 4, number of digits scanned (1..16)
- DIV, 50000, clk_i cycles per digit slot; must be ≥ GUARD+2
- GUARD, 2, cycles at start of each slot with all digits off
- PWM_BITS, 4, brightness resolution
- SEG_ACT_LOW, 1, 1 = seg_o active-low
- DIG_ACT_LOW, 1, 1 = dig_o active-low

Ports:
- clk_i  in  1  system clock; one clock domain.
- rst_i  in  1  reset, synchronous, active-low.
- data_i  in  4*N_DIGITS  hex nibbles; nibble k drives digit k; digit 0 is the rightmost.
- dp_i  in  N_DIGITS  decimal point per digit.
- blank_i  in  N_DIGITS  forces digit k dark, including DP.
- lzs_i  in  1  leading-zero suppression enable.
- load_i  in  1  one-cycle strobe that captures data_i, dp_i, blank_i and lzs_i.
- load_ack_o  out  1  one-cycle pulse when captured values become displayed.
- bright_i  in  PWM_BITS  brightness; sampled live, not shadowed.
- seg_o  out  8  {dp,g,f,e,d,c,b,a}.
- dig_o  out  N_DIGITS  digit enables, one-hot during the on-time.
- frame_o  out  1  one-cycle pulse at each frame boundary.

## Operation

- Prescaler `cnt` runs 0..DIV-1; `tick` = (cnt==DIV-1).
- Slot index `idx` runs 0..N_DIGITS-1:
  - advances on tick;
  - wraps from N_DIGITS-1 to 0;
  - the wrap tick is the frame boundary (`fb`).
- Three register sets:
  - pending: data, dp, blank, lzs, plus a pending flag;
  - display: the values currently scanned;
  - pwm_cnt: PWM_BITS wide, free-running, +1 every cycle.
- On load_i, pending ← inputs and the flag is set. Multiple loads before an fb: last wins, one ack.
- On fb with the flag set (value before the edge):
  - display ← pending;
  - load_ack_o pulses;
  - flag ← load_i of that same cycle.
- If load_i coincides with fb: the old pending contents commit and the new data waits for the next fb.
- Segment pattern, active-high internal encoding:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07;
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71;
  - bit7 = dp.
- Leading-zero suppression (when the display lzs is set):
  - scanning from digit N-1 downward, every zero nibble above the first non-zero nibble is suppressed;
  - digit 0 is never suppressed;
  - a suppressed digit shows only its DP, if set.
- blank has priority: blanked digit → all segments off.
- Digit enable for slot idx is asserted only when (cnt ≥ GUARD) && (pwm_cnt ≤ bright_i):
  - bright_i = all-ones → always on outside the guard;
  - bright_i = 0 → duty 1/2^PWM_BITS.
- Output polarity: seg_o is inverted when SEG_ACT_LOW; dig_o is inverted when DIG_ACT_LOW. "Off" means the inactive level.

## Timing

- All outputs are registered. seg_o, dig_o and frame_o reflect the cnt/idx/pwm_cnt state of the previous cycle (1-cycle latency).
- Frame period = N_DIGITS*DIV cycles. frame_o is high for exactly 1 cycle per frame.
- load_ack_o is asserted in the same cycle as frame_o, when a commit occurs.
- The first frame using new data starts the cycle after the ack.
- Load-to-ack latency:
  - worst case N_DIGITS*DIV+1 cycles;
  - minimum 2 cycles (load_i one cycle before fb).
- Reset (rst_i low at a clock edge), including mid-frame, takes effect at the next edge:
  - cnt, idx, pwm_cnt, flag = 0;
  - display and pending regs = 0, lzs = 0, blank = 0;
  - seg_o and dig_o = off levels (0xFF / all-ones with default params);
  - frame_o = 0, load_ack_o = 0.
- After reset release, the scan restarts at slot 0 with cnt = 0 and displays "0000". Loads issued during reset are discarded.
- Segment data must never change while dig_o is active. The guard cycles cover the slot transition.

## Test plan

- Reset and idle (N=4, DIV=8, GUARD=2): after rst_i low then high → seg_o=FF and dig_o=F during reset. Then:
  - frame_o every 32 cycles;
  - digit k is active-low, enabled for cycles 2..7 of slot k, with seg_o=C0;
  - bright_i=F.
- Load 0x1234 with dp_i=0001 at an arbitrary cycle:
  - load_ack_o coincides with the next frame_o;
  - following slots show seg_o F9, A4, B0 and 19 (digit 0 = 4+dp) on digits 3, 2, 1, 0 respectively.
- lzs_i=1 with data 0x0050:
  - digits 3 and 2 are dark;
  - digit 1 = 92, digit 0 = C0;
  - data 0x0000 → only digit 0 lit with C0.
- Two loads (0xAAAA then 0xBBBB) in the same frame → one ack; the display shows 83 on all digits. Load on the fb cycle → that data's ack arrives exactly one frame later.
- bright_i=0, PWM_BITS=4, DIV=64: within a slot, dig enable is asserted 1 cycle per 16 after the guard; bright_i=7 → 8 per 16.
- Reset asserted mid-slot with a pending load → outputs go to off levels next edge; no ack; after release the display shows 0000.
